// File: rtl/bcd_entry_to_bin_pkg.sv
// Shared types and constants for the BCD digit-entry to binary converter.
// Holds the FSM state type, the largest legal BCD digit, and accumulator sizing.
package bcd_entry_to_bin_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // The accumulator is as wide as the BCD entry. 10^N is always below 16^N,
  // so acc*10 + digit can never wrap inside the accumulator.
  function automatic int acc_width(input int n_dig);
    return 4 * n_dig;
  endfunction

endpackage

// File: rtl/bcd_entry_to_bin_if.sv
// Front-panel bus between the keypad/strobe logic and the BCD-to-binary converter.
// The master drives digits and commands. The slave returns the entry, status, and result.
interface bcd_entry_to_bin_if #(
  parameter int N_DIG = 4,
  parameter int N_OUT = 10
);

  logic [3:0]         digit_in;
  logic               digit_valid;
  logic               convert;
  logic               clear;
  logic [4*N_DIG-1:0] digits_out;
  logic               busy;
  logic [N_OUT-1:0]   bin_out;
  logic               bin_valid;
  logic               ovf;
  logic               err;

  modport master (
    output digit_in, digit_valid, convert, clear,
    input  digits_out, busy, bin_out, bin_valid, ovf, err
  );

  modport slave (
    input  digit_in, digit_valid, convert, clear,
    output digits_out, busy, bin_out, bin_valid, ovf, err
  );

endinterface

// File: rtl/bcd_entry_to_bin_entry_reg.sv
// N_DIG-nibble calculator-style entry register: new digits enter as the LSD and the
// old MSD is discarded. Non-BCD digits are rejected with a one-cycle err pulse.
module bcd_entry_reg
  import bcd_entry_to_bin_pkg::*;
#(
  parameter int N_DIG = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               freeze,
  input  logic [3:0]         digit_in,
  input  logic               digit_valid,
  output logic [4*N_DIG-1:0] entry,
  output logic [4*N_DIG-1:0] entry_next,
  output logic               err
);

  logic err_next;

  // entry_next is exported so a conversion started in the same cycle sees the new digit.
  always_comb begin
    entry_next = entry;
    err_next   = 1'b0;
    if (clear) begin
      entry_next = '0;
    end else if (!freeze && digit_valid) begin
      if (digit_in <= BCD_MAX) begin
        entry_next = (entry << 4) | (4*N_DIG)'(digit_in);
      end else begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= '0;
      err   <= 1'b0;
    end else begin
      entry <= entry_next;
      err   <= err_next;
    end
  end

endmodule

// File: rtl/bcd_entry_to_bin.sv
// Sequential BCD-to-binary converter. It converts a snapshot of the entry MSD-first
// with acc = acc*10 + digit, one digit per cycle, and saturates at 2^N_OUT-1.
module bcd_entry_to_bin
  import bcd_entry_to_bin_pkg::*;
#(
  parameter int N_DIG = 4,
  parameter int N_OUT = 10
) (
  input logic               clk,
  input logic               rst_n,
  bcd_entry_to_bin_if.slave bus
);

  localparam int ACC_W = acc_width(N_DIG);
  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(N_DIG - 1);
  localparam logic [ACC_W-1:0] SAT_LIMIT = ACC_W'((64'd1 << N_OUT) - 64'd1);

  state_t             state;
  logic [ACC_W-1:0]   work;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_step;
  logic [IDX_W-1:0]   idx;
  logic               busy_q;
  logic [N_OUT-1:0]   bin_q;
  logic               ovf_q;
  logic               valid_q;
  logic [4*N_DIG-1:0] entry;
  logic [4*N_DIG-1:0] entry_next;
  logic               entry_err;

  bcd_entry_reg #(
    .N_DIG (N_DIG)
  ) u_entry (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (bus.clear),
    .freeze      (state == CONV),
    .digit_in    (bus.digit_in),
    .digit_valid (bus.digit_valid),
    .entry       (entry),
    .entry_next  (entry_next),
    .err         (entry_err)
  );

  // The working copy is shifted left each step, so its top nibble is always digit[idx].
  always_comb begin
    acc_step = '0;
    acc_step = acc * ACC_W'(10) + ACC_W'(work[ACC_W-1 -: 4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      work    <= '0;
      acc     <= '0;
      idx     <= '0;
      busy_q  <= 1'b0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.clear) begin
        state  <= IDLE;
        work   <= '0;
        acc    <= '0;
        idx    <= '0;
        busy_q <= 1'b0;
        bin_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.convert) begin
              work   <= entry_next;
              acc    <= '0;
              idx    <= IDX_FIRST;
              busy_q <= 1'b1;
              state  <= CONV;
            end
          end
          CONV: begin
            acc  <= acc_step;
            work <= work << 4;
            if (idx == '0) begin
              state   <= IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              if (acc_step > SAT_LIMIT) begin
                bin_q <= '1;
                ovf_q <= 1'b1;
              end else begin
                bin_q <= N_OUT'(acc_step);
                ovf_q <= 1'b0;
              end
            end else begin
              idx <= idx - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.digits_out = entry;
  assign bus.busy       = busy_q;
  assign bus.bin_out    = bin_q;
  assign bus.bin_valid  = valid_q;
  assign bus.ovf        = ovf_q;
  assign bus.err        = entry_err;

endmodule

// File: tb/tb_bcd_entry_to_bin.sv
// Self-checking bench for bcd_entry_to_bin. A cycle model predicts the entry and status,
// and a queue of expected conversion results is popped on every bin_valid pulse.
module tb_bcd_entry_to_bin;

  localparam int N_DIG = 4;
  localparam int N_OUT = 10;
  localparam int SAT   = (1 << N_OUT) - 1;

  typedef struct {
    int bin;
    bit ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   vectors;
  int   miscompares;

  logic [15:0] m_entry;
  int          m_conv_left;
  bit          m_err;
  bit          m_valid;
  int          m_bin;
  bit          m_ovf;
  int          p_bin;
  bit          p_ovf;

  bcd_entry_to_bin_if #(.N_DIG(N_DIG), .N_OUT(N_OUT)) bus ();

  bcd_entry_to_bin #(
    .N_DIG (N_DIG),
    .N_OUT (N_OUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bcdValue(input logic [15:0] e);
    int v;
    v = 0;
    for (int k = 3; k >= 0; k--) v = v * 10 + int'(e[4*k +: 4]);
    return v;
  endfunction

  // Advance the model by one clock edge for the given inputs.
  task automatic modelEdge(input logic [3:0] d, input bit dv, input bit cv, input bit clr);
    int v;
    m_err   = 0;
    m_valid = 0;
    if (clr) begin
      if (m_conv_left > 0) void'(sb.pop_back());
      m_entry     = '0;
      m_conv_left = 0;
      m_bin       = 0;
      m_ovf       = 0;
    end else if (m_conv_left > 0) begin
      m_conv_left--;
      if (m_conv_left == 0) begin
        m_valid = 1;
        m_bin   = p_bin;
        m_ovf   = p_ovf;
      end
    end else begin
      if (dv) begin
        if (d <= 4'd9) m_entry = {m_entry[11:0], d};
        else m_err = 1;
      end
      if (cv) begin
        v     = bcdValue(m_entry);
        p_ovf = (v > SAT);
        p_bin = p_ovf ? SAT : v;
        sb.push_back('{bin: p_bin, ovf: p_ovf});
        m_conv_left = N_DIG;
      end
    end
  endtask

  // Drive one cycle of inputs from a negedge, then check all outputs at the next negedge.
  task automatic applyStimulus(input logic [3:0] d, input bit dv, input bit cv, input bit clr);
    bus.digit_in    = d;
    bus.digit_valid = dv;
    bus.convert     = cv;
    bus.clear       = clr;
    modelEdge(d, dv, cv, clr);
    @(negedge clk);
    checkOutput("digits_out", 32'(bus.digits_out), 32'(m_entry));
    checkOutput("busy", 32'(bus.busy), 32'(m_conv_left > 0));
    checkOutput("err", 32'(bus.err), 32'(m_err));
    checkOutput("bin_valid", 32'(bus.bin_valid), 32'(m_valid));
    checkOutput("bin_out", 32'(bus.bin_out), 32'(m_bin));
    checkOutput("ovf", 32'(bus.ovf), 32'(m_ovf));
    bus.digit_in    = '0;
    bus.digit_valid = 1'b0;
    bus.convert     = 1'b0;
    bus.clear       = 1'b0;
  endtask

  task automatic enterDigit(input logic [3:0] d);
    applyStimulus(d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_digits"}, 32'(bus.digits_out), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_bin"}, 32'(bus.bin_out), 32'd0);
    checkOutput({tag, "_valid"}, 32'(bus.bin_valid), 32'd0);
    checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    checkOutput({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  task automatic modelReset();
    sb.delete();
    m_entry     = '0;
    m_conv_left = 0;
    m_err       = 0;
    m_valid     = 0;
    m_bin       = 0;
    m_ovf       = 0;
  endtask

  // Scoreboard: every bin_valid pulse must match the oldest outstanding conversion.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.bin_valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_bin_out", 32'(bus.bin_out), 32'(e.bin));
        checkOutput("sb_ovf", 32'(bus.ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    int r;
    vectors     = 0;
    miscompares = 0;
    modelReset();
    p_bin           = 0;
    p_ovf           = 0;
    bus.digit_in    = '0;
    bus.digit_valid = 1'b0;
    bus.convert     = 1'b0;
    bus.clear       = 1'b0;
    rst_n           = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    $display("[TB] normal entry 1023");
    enterDigit(4'd1); enterDigit(4'd0); enterDigit(4'd2); enterDigit(4'd3);
    checkOutput("entry_1023", 32'(bus.digits_out), 32'h1023);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0);
    idleCycles(5);

    $display("[TB] overflow 9999 then 0007");
    repeat (4) enterDigit(4'd9);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0);
    idleCycles(5);
    checkOutput("sat_ovf", 32'(bus.ovf), 32'd1);
    checkOutput("sat_bin", 32'(bus.bin_out), 32'd1023);
    enterDigit(4'd0); enterDigit(4'd0); enterDigit(4'd0); enterDigit(4'd7);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0);
    idleCycles(5);
    checkOutput("seven_bin", 32'(bus.bin_out), 32'd7);

    $display("[TB] invalid digit and MSD discard");
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
    enterDigit(4'd5);
    enterDigit(4'hA);
    checkOutput("invalid_keeps", 32'(bus.digits_out), 32'h0005);
    idleCycles(1);
    enterDigit(4'd1); enterDigit(4'd2); enterDigit(4'd3); enterDigit(4'd4); enterDigit(4'd5);
    checkOutput("discard_msd", 32'(bus.digits_out), 32'h2345);

    $display("[TB] same-cycle digit and convert, ignored inputs while busy");
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
    enterDigit(4'd1); enterDigit(4'd2);
    applyStimulus(4'd8, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'd3, 1'b1, 1'b1, 1'b0);
    idleCycles(5);
    checkOutput("result_128", 32'(bus.bin_out), 32'd128);

    $display("[TB] clear mid-conversion");
    enterDigit(4'd6);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0);
    idleCycles(1);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
    idleCycles(4);

    $display("[TB] reset mid-conversion");
    enterDigit(4'd9);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0);
    idleCycles(1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("async_rst");
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    enterDigit(4'd4); enterDigit(4'd2);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0);
    idleCycles(5);
    checkOutput("result_42", 32'(bus.bin_out), 32'd42);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 15));
      if (r <= 10) applyStimulus(4'(r), 1'b1, 1'b0, 1'b0);
      else if (r <= 12) applyStimulus(4'(r), 1'b0, 1'b1, 1'b0);
      else if (r == 13) applyStimulus(4'($urandom_range(0, 9)), 1'b1, 1'b1, 1'b0);
      else if (r == 14) applyStimulus(4'd0, 1'b0, 1'b0, 1'b0);
      else applyStimulus(4'd0, 1'b0, 1'b0, 1'b1);
    end
    idleCycles(6);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
